amm_traffic_master: RTL and testbench

- Avalon-MM burst master that turns single-transaction commands from the test-sequencing logic into read/write bursts on the memory interface.
- Its Avalon-MM outputs are the same read/write/burstcount/byteenable signals monitored by the measurement block.
- Write bursts carry a deterministic data pattern.
- Read-burst concurrency is capped to match the measurement block's four delay-counter slots.

---
 rtl/amm_traffic_master.sv | 158 +++++++++++++++
 tb/tb_amm_traffic_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_traffic_master.sv
// Avalon-MM burst master: turns single commands into write bursts carrying a
// seed-based data pattern, or into read bursts whose returns are tracked.
//
// state    | meaning
// IDLE     | waiting for a command; the only state that accepts one
// WR_BURST | issuing write words; one word goes out per cycle without waitrequest
// RD_REQ   | holding a read request until the slave accepts it
module amm_traffic_master #(
  parameter int AMM_ADDR_W   = 31,
  parameter int AMM_DATA_W   = 128,
  parameter int AMM_BURST_W  = 11,
  parameter int DATA_B_W     = 16,
  parameter int MAX_RD_OUTST = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic                              cmd_op_i,
  input  logic [AMM_ADDR_W-1:0]             cmd_addr_i,
  input  logic [AMM_BURST_W-1:0]            cmd_burst_i,
  input  logic [31:0]                       cmd_seed_i,
  input  logic [DATA_B_W-1:0]               cmd_byteen_i,
  output logic [AMM_ADDR_W-1:0]             address_o,
  output logic                              read_o,
  output logic                              write_o,
  output logic [AMM_DATA_W-1:0]             writedata_o,
  output logic [AMM_BURST_W-1:0]            burstcount_o,
  output logic [DATA_B_W-1:0]               byteenable_o,
  input  logic                              waitrequest_i,
  input  logic                              readdatavalid_i,
  output logic                              busy_o,
  output logic [$clog2(MAX_RD_OUTST):0]     rd_outst_o,
  output logic                              rd_unexp_o
);

  localparam int LANES = AMM_DATA_W / 32;
  localparam int PTR_W = (MAX_RD_OUTST > 1) ? $clog2(MAX_RD_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_RD_OUTST) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_REQ   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_seed;
  logic [AMM_BURST_W-1:0] r_k;
  logic [AMM_BURST_W-1:0] r_rem;
  logic                   r_rem_act;
  logic [AMM_BURST_W-1:0] r_fifo [MAX_RD_OUTST];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_outst;

  logic                   w_ready;
  logic [AMM_BURST_W-1:0] w_burst;
  logic [31:0]            w_next_word;
  logic                   w_fifo_empty;
  logic [AMM_BURST_W-1:0] w_rem_cur;
  logic                   w_push;
  logic                   w_pop;

  assign w_ready      = (r_state == IDLE) && (r_outst < CNT_W'(MAX_RD_OUTST));
  assign w_burst      = (cmd_burst_i == '0) ? AMM_BURST_W'(1) : cmd_burst_i;
  assign w_next_word  = r_seed + 32'(r_k) + 32'd1;
  assign w_fifo_empty = (r_outst == '0);
  // Remaining count comes from the FIFO head until the burst's first word lands.
  assign w_rem_cur    = r_rem_act ? r_rem : r_fifo[r_rd_ptr];
  assign w_push       = (r_state == RD_REQ) && !waitrequest_i;
  assign w_pop        = readdatavalid_i && !w_fifo_empty && (w_rem_cur == AMM_BURST_W'(1));

  assign cmd_ready_o  = w_ready && !rst_i;
  assign busy_o       = (r_state != IDLE) || (r_outst != '0);
  assign rd_outst_o   = r_outst;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_seed       <= '0;
      r_k          <= '0;
      r_rem        <= '0;
      r_rem_act    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_outst      <= '0;
      address_o    <= '0;
      read_o       <= 1'b0;
      write_o      <= 1'b0;
      writedata_o  <= '0;
      burstcount_o <= '0;
      byteenable_o <= '0;
      rd_unexp_o   <= 1'b0;
      for (int i = 0; i < MAX_RD_OUTST; i++) r_fifo[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid_i && w_ready) begin
            address_o    <= cmd_addr_i;
            burstcount_o <= w_burst;
            r_k          <= '0;
            if (cmd_op_i) begin
              read_o       <= 1'b1;
              byteenable_o <= '1;
              r_state      <= RD_REQ;
            end else begin
              write_o      <= 1'b1;
              byteenable_o <= cmd_byteen_i;
              r_seed       <= cmd_seed_i;
              writedata_o  <= {LANES{cmd_seed_i}};
              r_state      <= WR_BURST;
            end
          end
        end
        WR_BURST: begin
          if (!waitrequest_i) begin
            if (r_k == burstcount_o - AMM_BURST_W'(1)) begin
              write_o <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_k         <= r_k + AMM_BURST_W'(1);
              writedata_o <= {LANES{w_next_word}};
            end
          end
        end
        RD_REQ: begin
          if (!waitrequest_i) begin
            read_o  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_push) begin
        r_fifo[r_wr_ptr] <= burstcount_o;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end

      if (readdatavalid_i) begin
        if (w_fifo_empty) begin
          rd_unexp_o <= 1'b1;
        end else if (w_pop) begin
          r_rem_act <= 1'b0;
          r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        end else begin
          r_rem     <= w_rem_cur - AMM_BURST_W'(1);
          r_rem_act <= 1'b1;
        end
      end

      if (w_push && !w_pop) r_outst <= r_outst + CNT_W'(1);
      else if (w_pop && !w_push) r_outst <= r_outst - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_amm_traffic_master.sv
// Bench for amm_traffic_master: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model built on a queue.
module tb_amm_traffic_master;
  localparam int AW = 31, DW = 128, BW = 11, BEW = 16, MAXO = 4, LN = DW / 32;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           cmd_valid_i, cmd_ready_o, cmd_op_i;
  logic [AW-1:0]  cmd_addr_i;
  logic [BW-1:0]  cmd_burst_i;
  logic [31:0]    cmd_seed_i;
  logic [BEW-1:0] cmd_byteen_i;
  logic [AW-1:0]  address_o;
  logic           read_o, write_o;
  logic [DW-1:0]  writedata_o;
  logic [BW-1:0]  burstcount_o;
  logic [BEW-1:0] byteenable_o;
  logic           waitrequest_i, readdatavalid_i, busy_o, rd_unexp_o;
  logic [2:0]     rd_outst_o;

  always #5 clk_i = ~clk_i;

  amm_traffic_master dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_burst_i(cmd_burst_i), .cmd_seed_i(cmd_seed_i),
    .cmd_byteen_i(cmd_byteen_i), .address_o(address_o), .read_o(read_o),
    .write_o(write_o), .writedata_o(writedata_o), .burstcount_o(burstcount_o),
    .byteenable_o(byteenable_o), .waitrequest_i(waitrequest_i),
    .readdatavalid_i(readdatavalid_i), .busy_o(busy_o), .rd_outst_o(rd_outst_o),
    .rd_unexp_o(rd_unexp_o)
  );

  int total = 0, bad = 0;

  // Model: which burst is being issued (0 none, 1 write, 2 read), its fields,
  // and a queue holding the words still owed by each read burst in flight.
  int             m_mode, m_k, m_burst, n_wr_hi;
  logic [31:0]    m_seed;
  logic [AW-1:0]  m_addr;
  logic [BEW-1:0] m_be;
  int             m_q[$];
  bit             m_unexp, m_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] w);
    logic [DW-1:0] v;
    for (int i = 0; i < LN; i++) v[i*32 +: 32] = w;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_burst = 0; m_seed = '0; m_addr = '0; m_be = '0;
    m_q.delete(); m_unexp = 0; m_acc = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 128'(address_o), 128'(0));
    chk({tag, "_read"}, 128'(read_o), 128'(0));
    chk({tag, "_write"}, 128'(write_o), 128'(0));
    chk({tag, "_wdata"}, 128'(writedata_o), 128'(0));
    chk({tag, "_bcount"}, 128'(burstcount_o), 128'(0));
    chk({tag, "_be"}, 128'(byteenable_o), 128'(0));
    chk({tag, "_ready"}, 128'(cmd_ready_o), 128'(0));
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    chk({tag, "_outst"}, 128'(rd_outst_o), 128'(0));
    chk({tag, "_unexp"}, 128'(rd_unexp_o), 128'(0));
  endtask

  task automatic check_outputs();
    bit idle;
    idle = (m_mode == 0);
    chk("write_o", 128'(write_o), 128'(m_mode == 1));
    chk("read_o", 128'(read_o), 128'(m_mode == 2));
    if (!idle) begin
      chk("address", 128'(address_o), 128'(m_addr));
      chk("burstcount", 128'(burstcount_o), 128'(m_burst));
      chk("byteenable", 128'(byteenable_o), 128'((m_mode == 1) ? m_be : {BEW{1'b1}}));
    end
    if (m_mode == 1) chk("writedata", 128'(writedata_o), 128'(pat(m_seed + 32'(m_k))));
    chk("rd_outst", 128'(rd_outst_o), 128'(m_q.size()));
    chk("rd_unexp", 128'(rd_unexp_o), 128'(m_unexp));
    chk("cmd_ready", 128'(cmd_ready_o), 128'(idle && (m_q.size() < MAXO)));
    chk("busy", 128'(busy_o), 128'(!idle || (m_q.size() != 0)));
    if (write_o) n_wr_hi++;
  endtask

  // One clock: inputs are stable here, the model advances on the same values
  // the DUT sees at the edge, and outputs are compared 1 time unit later.
  task automatic step();
    bit rdy;
    rdy   = (m_mode == 0) && (m_q.size() < MAXO);
    m_acc = 0;
    @(posedge clk_i);
    if (readdatavalid_i) begin
      if (m_q.size() == 0) m_unexp = 1;
      else begin
        m_q[0] = m_q[0] - 1;
        if (m_q[0] == 0) void'(m_q.pop_front());
      end
    end
    case (m_mode)
      1: if (!waitrequest_i) begin
           if (m_k == m_burst - 1) m_mode = 0;
           else m_k++;
         end
      2: if (!waitrequest_i) begin
           m_q.push_back(m_burst);
           m_mode = 0;
         end
      default: if (cmd_valid_i && rdy) begin
           m_acc   = 1;
           m_addr  = cmd_addr_i;
           m_burst = (cmd_burst_i == '0) ? 1 : int'(cmd_burst_i);
           m_seed  = cmd_seed_i;
           m_be    = cmd_byteen_i;
           m_k     = 0;
           m_mode  = cmd_op_i ? 2 : 1;
         end
    endcase
    #1;
    check_outputs();
  endtask

  task automatic issue(input logic op, input logic [AW-1:0] addr, input logic [BW-1:0] burst,
                       input logic [31:0] seed, input logic [BEW-1:0] be, input int max);
    bit got;
    got = 0;
    cmd_op_i = op; cmd_addr_i = addr; cmd_burst_i = burst; cmd_seed_i = seed;
    cmd_byteen_i = be; cmd_valid_i = 1'b1;
    for (int i = 0; i < max && !got; i++) begin
      step();
      got = m_acc;
    end
    cmd_valid_i = 1'b0;
    chk("accept", 128'(got), 128'(1));
  endtask

  task automatic finish_burst(input int max);
    for (int i = 0; i < max && m_mode != 0; i++) step();
    chk("burst_done", 128'(write_o | read_o), 128'(0));
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && m_q.size() != 0; i++) begin
      readdatavalid_i = 1'b1;
      step();
    end
    readdatavalid_i = 1'b0;
    chk("drain", 128'(rd_outst_o), 128'(0));
  endtask

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 0; cmd_op_i = 0; cmd_addr_i = '0; cmd_burst_i = '0;
    cmd_seed_i = '0; cmd_byteen_i = '0; waitrequest_i = 0; readdatavalid_i = 0;
    model_reset();
    n_wr_hi = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset");
    rst_i = 1'b0;
    step();

    // write burst, no backpressure
    n_wr_hi = 0;
    issue(1'b0, 'h100, 4, 'h10, 'hFFFF, 5);
    finish_burst(20);
    chk("wr4_cycles", 128'(n_wr_hi), 128'(4));
    step();

    // same write with waitrequest on burst cycles 2-3
    n_wr_hi = 0;
    issue(1'b0, 'h100, 4, 'h10, 'hFFFF, 5);
    step();
    waitrequest_i = 1'b1;
    step();
    step();
    waitrequest_i = 1'b0;
    finish_burst(20);
    chk("wr4_wait_cycles", 128'(n_wr_hi), 128'(6));
    step();

    // four reads fill the tracker, the fifth waits for a completed burst
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, AW'('h1000 + 'h40 * i), 2, '0, '0, 5);
      finish_burst(10);
    end
    chk("rd_full_outst", 128'(rd_outst_o), 128'(4));
    chk("rd_full_ready", 128'(cmd_ready_o), 128'(0));
    cmd_op_i = 1'b1; cmd_addr_i = 'h2000; cmd_burst_i = 2; cmd_valid_i = 1'b1;
    repeat (3) step();
    readdatavalid_i = 1'b1;
    step();
    step();
    readdatavalid_i = 1'b0;
    chk("rd_after_pop_outst", 128'(rd_outst_o), 128'(3));
    issue(1'b1, 'h2000, 2, '0, '0, 4);
    finish_burst(10);
    chk("rd_refill_outst", 128'(rd_outst_o), 128'(4));
    drain(40);
    step();

    // last word of a burst in the same cycle a new read is accepted
    issue(1'b1, 'h3000, 3, '0, '0, 5);
    finish_burst(10);
    waitrequest_i = 1'b1;
    issue(1'b1, 'h3100, 2, '0, '0, 5);
    readdatavalid_i = 1'b1;
    step();
    step();
    chk("pushpop_before", 128'(rd_outst_o), 128'(1));
    waitrequest_i = 1'b0;
    step();
    readdatavalid_i = 1'b0;
    chk("pushpop_after", 128'(rd_outst_o), 128'(1));
    readdatavalid_i = 1'b1;
    step();
    readdatavalid_i = 1'b0;
    chk("fifo_order_mid", 128'(rd_outst_o), 128'(1));
    drain(10);
    step();

    // unexpected read data
    readdatavalid_i = 1'b1;
    step();
    readdatavalid_i = 1'b0;
    chk("unexp_set", 128'(rd_unexp_o), 128'(1));
    repeat (3) step();
    chk("unexp_sticky", 128'(rd_unexp_o), 128'(1));
    chk("unexp_outst", 128'(rd_outst_o), 128'(0));

    // reset in the middle of an 8-word write
    issue(1'b0, 'h400, 8, 'hA0, 'h0F0F, 5);
    step();
    step();
    chk("mid_k2_data", 128'(writedata_o), 128'(pat(32'hA2)));
    #2;
    rst_i = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    step();
    n_wr_hi = 0;
    issue(1'b0, 'h500, 1, 'hB0, 'hFFFF, 5);
    finish_burst(10);
    chk("post_rst_cycles", 128'(n_wr_hi), 128'(1));
    step();
    n_wr_hi = 0;
    issue(1'b0, 'h600, 0, 'hC0, 'h00FF, 5);
    finish_burst(10);
    chk("burst0_cycles", 128'(n_wr_hi), 128'(1));
    step();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      cmd_valid_i     = 1'($urandom_range(0, 1));
      cmd_op_i        = 1'($urandom_range(0, 1));
      cmd_addr_i      = AW'($urandom);
      cmd_burst_i     = BW'($urandom_range(0, 5));
      cmd_seed_i      = $urandom;
      cmd_byteen_i    = BEW'($urandom);
      waitrequest_i   = ($urandom_range(0, 2) == 0);
      readdatavalid_i = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      step();
    end
    cmd_valid_i = 1'b0;
    waitrequest_i = 1'b0;
    readdatavalid_i = 1'b0;
    finish_burst(20);
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
